// File: rtl/meas_sequencer.sv
// Multi-channel measurement sequencer: runs a frequency or interval measurement,
// then hands the result to the transmit engine, once or continuously until abort.
`timescale 1ns/1ps
module meas_sequencer #(
  parameter int NCH       = 4,
  parameter int CHW       = $clog2(NCH),
  parameter int TO_CYCLES = 1000000,
  parameter int RUNW      = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [CHW-1:0]  cmd_ch,
  input  logic            cmd_cont,
  input  logic            abort,
  output logic            f_start,
  input  logic            f_busy,
  output logic            t_start,
  input  logic            t_busy,
  output logic            c_start,
  input  logic            c_busy,
  output logic [CHW-1:0]  sel_a,
  output logic [CHW-1:0]  sel_b,
  output logic [1:0]      mode,
  output logic            done,
  output logic [1:0]      err,
  output logic [RUNW-1:0] runs
);

  typedef enum logic [2:0] {
    S_IDLE, S_M_START, S_M_ACK, S_M_WAIT, S_C_START, S_C_ACK, S_C_WAIT
  } state_t;

  localparam int TOW = $clog2(TO_CYCLES);
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ABORT   = 2'b11;

  state_t         state, state_next;
  logic [TOW-1:0] to_cnt;
  logic           cont;
  logic [1:0]     err_next;
  logic           run_done;
  logic           illegal, meas_busy, waiting, to_hit;
  logic [CHW:0]   ch_inc;
  logic [CHW-1:0] ch_next;

  // Channel index may exceed NCH-1 only when NCH is not a power of two.
  assign illegal   = (cmd_op == 2'b11) || ({1'b0, cmd_ch} >= (CHW+1)'(NCH));
  assign ch_inc    = {1'b0, cmd_ch} + (CHW+1)'(1);
  assign ch_next   = (ch_inc >= (CHW+1)'(NCH)) ? CHW'(ch_inc - (CHW+1)'(NCH))
                                               : ch_inc[CHW-1:0];
  assign meas_busy = (mode == 2'b00) ? f_busy : t_busy;
  assign waiting   = (state == S_M_ACK) || (state == S_M_WAIT) ||
                     (state == S_C_ACK) || (state == S_C_WAIT);
  assign to_hit    = (to_cnt == TOW'(TO_CYCLES - 1));

  assign cmd_ready = (state == S_IDLE);
  assign f_start   = (state == S_M_START) && (mode == 2'b00);
  assign t_start   = (state == S_M_START) && (mode != 2'b00);
  assign c_start   = (state == S_C_START);
  assign done      = run_done && !rst;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_next = state;
    err_next   = err;
    run_done   = 1'b0;
    case (state)
      S_IDLE: if (cmd_valid) begin
        err_next   = illegal ? ERR_ILLEGAL : ERR_NONE;
        state_next = illegal ? S_IDLE : S_M_START;
      end
      S_M_START: state_next = S_M_ACK;
      S_M_ACK:
        if (meas_busy)   state_next = S_M_WAIT;
        else if (to_hit) begin state_next = S_IDLE; err_next = ERR_TIMEOUT; end
      S_M_WAIT:
        if (!meas_busy)  state_next = S_C_START;
        else if (to_hit) begin state_next = S_IDLE; err_next = ERR_TIMEOUT; end
      S_C_START: state_next = S_C_ACK;
      S_C_ACK:
        if (c_busy)      state_next = S_C_WAIT;
        else if (to_hit) begin state_next = S_IDLE; err_next = ERR_TIMEOUT; end
      S_C_WAIT:
        if (!c_busy) begin
          run_done   = 1'b1;
          state_next = cont ? S_M_START : S_IDLE;
        end else if (to_hit) begin
          state_next = S_IDLE;
          err_next   = ERR_TIMEOUT;
        end
      default: state_next = S_IDLE;
    endcase
    // Abort outranks both the awaited busy edge and the timeout.
    if (abort && (state != S_IDLE)) begin
      state_next = S_IDLE;
      err_next   = ERR_ABORT;
      run_done   = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      to_cnt <= '0;
      cont   <= 1'b0;
      sel_a  <= '0;
      sel_b  <= '0;
      mode   <= 2'b00;
      err    <= ERR_NONE;
      runs   <= '0;
    end else begin
      state <= state_next;
      err   <= err_next;
      if (state_next != state) to_cnt <= '0;
      else if (waiting)        to_cnt <= to_cnt + TOW'(1);
      if ((state == S_IDLE) && cmd_valid) begin
        mode  <= cmd_op;
        sel_a <= cmd_ch;
        sel_b <= ch_next;
        cont  <= cmd_cont;
        runs  <= '0;
      end else if (run_done && (runs != {RUNW{1'b1}})) begin
        runs <= runs + RUNW'(1);
      end
    end
  end

endmodule

// File: tb/tb_meas_sequencer.sv
// Self-checking bench for meas_sequencer: engine models, a transaction-level
// reference model compared every cycle, and directed scenarios with literal checks.
`timescale 1ns/1ps
module tb_meas_sequencer;

  localparam int NCH = 4;
  localparam int CHW = 2;
  localparam int TO  = 16;
  localparam int RUN_MAX = 65535;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [CHW-1:0] cmd_ch = '0;
  logic cmd_cont = 1'b0;
  logic abort = 1'b0;
  logic f_start, t_start, c_start;
  logic f_busy = 1'b0, t_busy = 1'b0, c_busy = 1'b0;
  logic [CHW-1:0] sel_a, sel_b;
  logic [1:0] mode, err;
  logic done;
  logic [15:0] runs;

  meas_sequencer #(.NCH(NCH), .CHW(CHW), .TO_CYCLES(TO), .RUNW(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_cont(cmd_cont), .abort(abort),
    .f_start(f_start), .f_busy(f_busy), .t_start(t_start), .t_busy(t_busy),
    .c_start(c_start), .c_busy(c_busy), .sel_a(sel_a), .sel_b(sel_b),
    .mode(mode), .done(done), .err(err), .runs(runs)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Engine models: start seen -> busy after a rise delay, held for a duration.
  bit rand_mode = 1'b0;
  bit eng_stuck [3];
  int fixed_dur [3];
  logic eng_busy [3];
  bit eng_pend [3];
  int eng_cnt [3];
  int eng_dur [3];

  initial begin
    for (int e = 0; e < 3; e++) begin
      eng_busy[e] = 1'b0; eng_pend[e] = 1'b0; eng_cnt[e] = 0; eng_dur[e] = 1;
      eng_stuck[e] = 1'b0; fixed_dur[e] = 4;
    end
    forever begin
      @(posedge clk); #1;
      for (int e = 0; e < 3; e++) begin
        logic st;
        st = (e == 0) ? f_start : (e == 1) ? t_start : c_start;
        if (eng_busy[e]) begin
          if (eng_cnt[e] == 0) eng_busy[e] = 1'b0; else eng_cnt[e]--;
        end else if (eng_pend[e]) begin
          if (eng_cnt[e] == 0) begin
            eng_busy[e] = 1'b1; eng_pend[e] = 1'b0; eng_cnt[e] = eng_dur[e] - 1;
          end else eng_cnt[e]--;
        end
        if (st && !eng_stuck[e]) begin
          eng_pend[e] = 1'b1;
          eng_cnt[e]  = rand_mode ? int'($urandom_range(0, 3)) : 0;
          eng_dur[e]  = rand_mode ? int'($urandom_range(1, 20)) : fixed_dur[e];
        end
      end
      f_busy = eng_busy[0]; t_busy = eng_busy[1]; c_busy = eng_busy[2];
    end
  end

  // Reference model: a run is "active"; it is in its measure or transmit
  // phase, either about to issue that phase's start or waiting for busy to
  // rise (seen=0) and then fall (seen=1), with a per-wait cycle count.
  bit m_active = 0, m_tx = 0, m_due = 0, m_seen = 0, m_cont = 0;
  int m_wait = 0, m_runs = 0;
  logic [1:0] m_mode = 2'b00, m_err = 2'b00;
  logic [CHW-1:0] m_sela = '0, m_selb = '0;

  task automatic model_step();
    logic b;
    if (rst) begin
      m_active = 0; m_tx = 0; m_due = 0; m_seen = 0; m_cont = 0; m_wait = 0;
      m_runs = 0; m_mode = 2'b00; m_err = 2'b00; m_sela = '0; m_selb = '0;
    end else if (!m_active) begin
      if (cmd_valid) begin
        m_mode = cmd_op; m_sela = cmd_ch; m_cont = cmd_cont; m_runs = 0;
        m_selb = CHW'((int'(cmd_ch) + 1) % NCH);
        if (cmd_op == 2'b11 || int'(cmd_ch) >= NCH) m_err = 2'b01;
        else begin m_err = 2'b00; m_active = 1; m_tx = 0; m_due = 1; end
      end
    end else if (abort) begin
      m_active = 0; m_err = 2'b11;
    end else if (m_due) begin
      m_due = 0; m_seen = 0; m_wait = 0;
    end else begin
      b = m_tx ? c_busy : (m_mode == 2'b00 ? f_busy : t_busy);
      if (b != m_seen) begin
        if (!m_seen) begin m_seen = 1; m_wait = 0; end
        else if (!m_tx) begin m_tx = 1; m_due = 1; end
        else begin
          if (m_runs < RUN_MAX) m_runs++;
          if (m_cont) begin m_tx = 0; m_due = 1; end else m_active = 0;
        end
      end else if (m_wait == TO - 1) begin
        m_active = 0; m_err = 2'b10;
      end else m_wait++;
    end
  endtask

  bit mon_en = 1'b0;
  int cnt_f = 0, cnt_t = 0, cnt_c = 0, cnt_done = 0;
  logic e_f, e_t, e_c, e_done, e_ready;

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      e_ready = !m_active;
      e_f     = m_active && m_due && !m_tx && (m_mode == 2'b00);
      e_t     = m_active && m_due && !m_tx && (m_mode != 2'b00);
      e_c     = m_active && m_due && m_tx;
      e_done  = m_active && m_tx && !m_due && m_seen && !c_busy && !abort && !rst;
      check("cmd_ready", 32'(cmd_ready), 32'(e_ready));
      check("f_start",   32'(f_start),   32'(e_f));
      check("t_start",   32'(t_start),   32'(e_t));
      check("c_start",   32'(c_start),   32'(e_c));
      check("done",      32'(done),      32'(e_done));
      check("sel_a",     32'(sel_a),     32'(m_sela));
      check("sel_b",     32'(sel_b),     32'(m_selb));
      check("mode",      32'(mode),      32'(m_mode));
      check("err",       32'(err),       32'(m_err));
      check("runs",      32'(runs),      32'(m_runs));
      cnt_f += int'(f_start); cnt_t += int'(t_start);
      cnt_c += int'(c_start); cnt_done += int'(done);
      model_step();
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 400 && !cmd_ready; i++) tick();
    check("wait_ready_bound", 32'(cmd_ready), 32'd1);
  endtask

  task automatic quiesce();
    for (int i = 0; i < 400 && (f_busy || t_busy || c_busy || eng_pend[0] ||
                                eng_pend[1] || eng_pend[2]); i++) tick();
    check("quiesce_bound", 32'({f_busy, t_busy, c_busy}), 32'd0);
  endtask

  task automatic send(input logic [1:0] op, input int ch, input logic cont, input logic ab);
    wait_ready();
    cmd_valid = 1'b1; cmd_op = op; cmd_ch = CHW'(ch); cmd_cont = cont; abort = ab;
    tick();
    cmd_valid = 1'b0; abort = 1'b0;
  endtask

  int bf, bt, bc, bd, n, c_at, d_at, fall_at;
  logic prev;

  initial begin
    @(posedge clk); #2; mon_en = 1'b1;
    tick(); tick(); rst = 1'b0;
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_err",   32'(err),       32'd0);
    check("rst_runs",  32'(runs),      32'd0);
    check("rst_sel",   32'({sel_a, sel_b, mode}), 32'd0);

    // Single frequency run: F busy 5 cycles, C busy 8 cycles.
    fixed_dur[0] = 5; fixed_dur[1] = 5; fixed_dur[2] = 8;
    bc = cnt_c; bd = cnt_done;
    send(2'b00, 2, 1'b0, 1'b0);
    check("t1_f_start", 32'(f_start), 32'd1);
    check("t1_sel_a",   32'(sel_a),   32'd2);
    check("t1_sel_b",   32'(sel_b),   32'd3);
    check("t1_mode",    32'(mode),    32'd0);
    n = 0; c_at = 0; d_at = 0; fall_at = 0; prev = f_busy;
    while (!cmd_ready && n < 100) begin
      tick(); n++;
      if (prev && !f_busy) fall_at = n;
      prev = f_busy;
      if (c_start) c_at = n;
      if (done) d_at = n;
    end
    check("t1_c_after_fall", 32'(c_at - fall_at), 32'd1);
    check("t1_c_at",    32'(c_at), 32'd7);
    check("t1_done_at", 32'(d_at), 32'd16);
    check("t1_ready_at", 32'(n),   32'd17);
    check("t1_runs",    32'(runs), 32'd1);
    check("t1_dones",   32'(cnt_done - bd), 32'd1);
    check("t1_cstarts", 32'(cnt_c - bc), 32'd1);

    // Continuous interval on the wrap channel, aborted after the third done.
    quiesce();
    fixed_dur[1] = 3; fixed_dur[2] = 4;
    bt = cnt_t; bc = cnt_c; bd = cnt_done;
    send(2'b10, 3, 1'b1, 1'b0);
    check("t2_t_start", 32'(t_start), 32'd1);
    check("t2_sel_b",   32'(sel_b),   32'd0);
    for (int i = 0; i < 300 && (cnt_done - bd) < 3; i++) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    tick(); tick(); tick();
    check("t2_err",     32'(err),  32'd3);
    check("t2_runs",    32'(runs), 32'd3);
    check("t2_ready",   32'(cmd_ready), 32'd1);
    check("t2_cstarts", 32'(cnt_c - bc), 32'd3);
    check("t2_tstarts", 32'(cnt_t - bt), 32'd4);

    // Period with a T engine that never answers: 16 cycles in the ack wait.
    quiesce();
    eng_stuck[1] = 1'b1; bc = cnt_c;
    send(2'b01, 0, 1'b0, 1'b0);
    check("t3_t_start", 32'(t_start), 32'd1);
    n = 0;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    check("t3_cycles", 32'(n),   32'd17);
    check("t3_err",    32'(err), 32'd2);
    check("t3_no_c",   32'(cnt_c - bc), 32'd0);
    eng_stuck[1] = 1'b0;

    // Illegal opcode, then a legal command clears the error.
    bf = cnt_f; bt = cnt_t; bc = cnt_c;
    send(2'b11, 1, 1'b0, 1'b0);
    check("t4_err",   32'(err),       32'd1);
    check("t4_ready", 32'(cmd_ready), 32'd1);
    tick(); tick();
    check("t4_no_start", 32'((cnt_f - bf) + (cnt_t - bt) + (cnt_c - bc)), 32'd0);
    send(2'b00, 1, 1'b0, 1'b1);
    check("t4_err_clr", 32'(err), 32'd0);
    wait_ready();

    // Reset while waiting for the transmit engine.
    quiesce();
    send(2'b00, 0, 1'b0, 1'b0);
    for (int i = 0; i < 100 && !c_busy; i++) tick();
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("t5_rst_ready", 32'(cmd_ready), 32'd1);
    check("t5_rst_outs",  32'({sel_a, sel_b, mode, err, done}), 32'd0);
    check("t5_rst_runs",  32'(runs), 32'd0);

    // Abort in the same cycle c_busy falls.
    quiesce();
    bd = cnt_done;
    send(2'b00, 1, 1'b0, 1'b0);
    for (int i = 0; i < 100 && !c_busy; i++) tick();
    prev = c_busy;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (prev && !c_busy) begin abort = 1'b1; break; end
      prev = c_busy;
    end
    tick(); abort = 1'b0;
    check("t5_ab_err",   32'(err),  32'd3);
    check("t5_ab_runs",  32'(runs), 32'd0);
    check("t5_ab_done",  32'(cnt_done - bd), 32'd0);

    // cmd_valid held through a run: only one accept until back in IDLE.
    quiesce();
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_ch = 2'd1; cmd_cont = 1'b0;
    tick();
    cmd_op = 2'b01; cmd_ch = 2'd2;
    tick(); tick();
    check("t6_not_ready", 32'(cmd_ready), 32'd0);
    for (int i = 0; i < 100 && !cmd_ready; i++) tick();
    check("t6_runs_prev", 32'(runs), 32'd1);
    tick();
    cmd_valid = 1'b0;
    check("t6_runs_new", 32'(runs),    32'd0);
    check("t6_t_start",  32'(t_start), 32'd1);
    check("t6_sel_a",    32'(sel_a),   32'd2);
    wait_ready();

    // Randomised commands, engine timing, stuck engines, aborts and resets.
    rand_mode = 1'b1;
    for (int k = 0; k < 60; k++) begin
      for (int e = 0; e < 3; e++) eng_stuck[e] = ($urandom_range(0, 9) == 0);
      send(($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
           int'($urandom_range(0, NCH - 1)), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0));
      for (int i = 0; i < 150; i++) begin
        tick(); abort = 1'b0; rst = 1'b0;
        if (cmd_ready) break;
        if (cmd_cont && i == 120) abort = 1'b1;
        else if ($urandom_range(0, 49) == 0) abort = 1'b1;
        if ($urandom_range(0, 299) == 0) rst = 1'b1;
      end
      abort = 1'b0; rst = 1'b0;
      for (int e = 0; e < 3; e++) eng_stuck[e] = 1'b0;
    end
    quiesce();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
